mc_compare_accum: RTL and testbench
===================================

# mc_compare_accum

Multi-channel registered comparator with hit accumulation for the Monte Carlo estimator datapath. Each accepted beat compares CHANNELS operand pairs in parallel and adds the number of hits to a running count. A run covers a programmed number of beats and ends with a one-cycle done pulse, so the counting logic sits between the random-sample generators and the result readout.

## Interface
- INPUT_WIDTH, 4: width of each operand, unsigned.
- CHANNELS, 2: number of parallel comparisons per beat, ≥1.
- COUNT_WIDTH, 32: width of `n_samples`, `beats` and `hits`.

- clk  input  1  sole clock; all state changes on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begins a run when the block is in IDLE; ignored otherwise.
- n_samples  input  COUNT_WIDTH  number of beats in the run; latched on an accepted `start`.
- cmp_mode  input  1  0: hit = a>b; 1: hit = a>=b; latched on an accepted `start`.
- in_valid  input  1  `a` and `b` carry a beat.
- a  input  CHANNELS*INPUT_WIDTH  channel i occupies bits [i*INPUT_WIDTH +: INPUT_WIDTH].
- b  input  CHANNELS*INPUT_WIDTH  same packing as `a`.
- in_ready  output  1  block accepts a beat; high only in RUN.
- hits  output  COUNT_WIDTH  accumulated channel hits; saturating.
- beats  output  COUNT_WIDTH  beats accepted in the current or last run.
- sat  output  1  sticky; set when `hits` saturates.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  one-cycle pulse at the end of a run.

## Operation
- States:
  - IDLE -> RUN on `start`.
  - IDLE -> DONE on `start` with `n_samples`==0.
  - RUN -> DRAIN, or directly to DONE when no pipeline stage exists, when the final beat is accepted.
  - DRAIN -> DONE.
  - DONE -> IDLE unconditionally.
- Reset: state IDLE, and all outputs and internal registers go to 0.
- Accepted `start`:
  - Clears `hits`, `beats` and `sat`.
  - Latches `n_samples` and `cmp_mode`.
  - A `start` outside IDLE has no effect, including in the DONE cycle.
- Beat acceptance: a beat is accepted on an edge where `in_valid` and `in_ready` are both high. Each accepted beat:
  - Increments `beats` by 1.
  - Forms a CHANNELS-bit hit vector.
  - Adds popcount(vector) to `hits`.
- Saturation: if hits+popcount exceeds 2^COUNT_WIDTH-1, `hits` holds all-ones and `sat` is set.
- Final beat: `in_ready` deasserts in the cycle after the beat for which `beats` reaches `n_samples`. No further beats are accepted.
- Results: `hits`, `beats` and `sat` hold after DONE until the next accepted `start` or reset.
- `in_valid` low in RUN stalls the run indefinitely, with no timeout.
- Reset mid-run aborts the run without a `done` pulse.

## Timing
- `in_ready` rises in the cycle after the edge that accepts `start`.
- Hit latency:
  - Without pipeline: a beat accepted at edge E is reflected in `hits` and `beats` from edge E.
  - With pipeline: `beats` updates at E and `hits` updates at E+1.
- Without pipeline: the final beat at edge E gives DONE and `done`=1 in the cycle after E; IDLE follows at E+1.
- With pipeline: DRAIN is entered at E, DONE at E+1, and IDLE at E+2.
- `n_samples`==0: `done` pulses in the cycle after the edge that accepts `start`, with `hits`=0 and `beats`=0.
- Throughput: one beat per cycle in RUN.

## Configuration
- MC_CMP_PIPE_EN defined:
  - A register stage holds the hit vector between the compare and the popcount/accumulate.
  - DRAIN is used and hit latency is +1 cycle.
- MC_CMP_PIPE_EN undefined:
  - Compare, popcount and accumulate happen in one registered step.
  - DRAIN is never entered.

## Structure
- Package `mc_pkg`:
  - `mc_cmp_mode_e` (CMP_GT=0, CMP_GE=1).
  - `mc_accum_state_e` (IDLE, RUN, DRAIN, DONE).
- Sub-module `mc_popcount`:
  - Parameter WIDTH.
  - Combinational popcount of the hit vector, output width $clog2(WIDTH+1).

## Test plan
- CHANNELS=2, INPUT_WIDTH=4, cmp_mode=0, n_samples=3; beats a={5,1},{9,9},{15,0}, b={3,2},{9,8},{0,1} -> hits=3, beats=3, one `done` pulse, then `in_ready`=0.
- Same operand stream with cmp_mode=1 -> hits=4 ({9,9}>={9,8} contributes 2).
- n_samples=0 -> `done` in the cycle after `start`, `hits`=0, `in_ready` never high.
- n_samples=4 with `in_valid` toggling every other cycle, all hits -> hits=8 after 4 accepted beats; `start` pulsed mid-run is ignored.
- COUNT_WIDTH=3, CHANNELS=2, n_samples=5, all hits -> hits=7, sat=1, beats=5.
- Reset asserted two beats into a run -> all outputs 0 on the next cycle, no `done`, and a new `start` runs normally; repeat every case with MC_CMP_PIPE_EN and check the +1 `hits`/`done` latency.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types for the Monte Carlo compare/accumulate datapath.
package mc_pkg;

  // Comparison applied to every channel of a beat.
  typedef enum logic {
    CMP_GT = 1'b0,
    CMP_GE = 1'b1
  } mc_cmp_mode_e;

  // Run-control states of the accumulator.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mc_accum_state_e;

  // Per-channel hit decision from the raw greater-than and equal flags.
  function automatic logic mc_hit(input logic gt, input logic eq, input mc_cmp_mode_e mode);
    return gt | ((mode == CMP_GE) & eq);
  endfunction

endpackage

// File: rtl/mc_popcount.sv
// Combinational population count of a hit vector.
module mc_popcount #(
  parameter int unsigned WIDTH = 2
) (
  input  logic [WIDTH-1:0]             vec_i,
  output logic [$clog2(WIDTH+1)-1:0]   count_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  // Sum the set bits of the vector.
  always_comb begin
    count_o = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      count_o = count_o + CntW'(vec_i[i]);
    end
  end

endmodule

// File: rtl/mc_compare_accum.sv
// Multi-channel registered comparator with saturating hit accumulation.
// Optional build macro MC_CMP_PIPE_EN: registers the hit vector between the compare and the
// popcount/accumulate step, adding one cycle of hit latency and a DRAIN state.
module mc_compare_accum
  import mc_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH = 4,
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [COUNT_WIDTH-1:0]          n_samples,
  input  logic                            cmp_mode,
  input  logic                            in_valid,
  input  logic [CHANNELS*INPUT_WIDTH-1:0] a,
  input  logic [CHANNELS*INPUT_WIDTH-1:0] b,
  output logic                            in_ready,
  output logic [COUNT_WIDTH-1:0]          hits,
  output logic [COUNT_WIDTH-1:0]          beats,
  output logic                            sat,
  output logic                            busy,
  output logic                            done
);

  localparam int unsigned PopW = $clog2(CHANNELS + 1);

`ifdef MC_CMP_PIPE_EN
  localparam bit PipeEn = 1'b1;
`else
  localparam bit PipeEn = 1'b0;
`endif

  mc_accum_state_e          state_q, state_d;
  mc_cmp_mode_e             mode_q, mode_d;
  logic [COUNT_WIDTH-1:0]   n_q, n_d;
  logic [COUNT_WIDTH-1:0]   beats_q, beats_d;
  logic [COUNT_WIDTH-1:0]   hits_q, hits_d;
  logic                     sat_q, sat_d;

  logic [CHANNELS-1:0]      hit_vec;
  logic [CHANNELS-1:0]      acc_vec;
  logic                     acc_en;
  logic [PopW-1:0]          pop;
  logic [COUNT_WIDTH:0]     sum;
  logic                     beat_acc;
  logic                     last_beat;

  assign beat_acc  = in_valid && (state_q == RUN);
  // beats never exceeds n_q inside a run, so the increment cannot wrap here.
  assign last_beat = (beats_q + COUNT_WIDTH'(1)) == n_q;

  // Per-channel comparison of the presented operand pair.
  always_comb begin
    hit_vec = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      hit_vec[i] = mc_hit(a[i*INPUT_WIDTH +: INPUT_WIDTH] >  b[i*INPUT_WIDTH +: INPUT_WIDTH],
                          a[i*INPUT_WIDTH +: INPUT_WIDTH] == b[i*INPUT_WIDTH +: INPUT_WIDTH],
                          mode_q);
    end
  end

`ifdef MC_CMP_PIPE_EN
  logic [CHANNELS-1:0] vec_q;
  logic                vec_vld_q;

  // Hit-vector stage; its contents are accumulated one edge after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q     <= '0;
      vec_vld_q <= 1'b0;
    end else begin
      vec_q     <= beat_acc ? hit_vec : '0;
      vec_vld_q <= beat_acc;
    end
  end

  assign acc_vec = vec_q;
  assign acc_en  = vec_vld_q;
`else
  assign acc_vec = hit_vec;
  assign acc_en  = beat_acc;
`endif

  mc_popcount #(
    .WIDTH (CHANNELS)
  ) u_popcount (
    .vec_i   (acc_vec),
    .count_o (pop)
  );

  // One extra bit catches overflow for saturation.
  assign sum = {1'b0, hits_q} + (COUNT_WIDTH + 1)'(pop);

  // Next-state: run control, start latching, beat counting and hit accumulation.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    n_d     = n_q;
    beats_d = beats_q;
    hits_d  = hits_q;
    sat_d   = sat_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mc_cmp_mode_e'(cmp_mode);
          n_d     = n_samples;
          beats_d = '0;
          hits_d  = '0;
          sat_d   = 1'b0;
          state_d = (n_samples == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (beat_acc) begin
          beats_d = beats_q + COUNT_WIDTH'(1);
          if (last_beat) begin
            state_d = PipeEn ? DRAIN : DONE;
          end
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Accumulation never coincides with an accepted start, which only happens in IDLE.
    if (acc_en) begin
      if (sum[COUNT_WIDTH]) begin
        hits_d = '1;
        sat_d  = 1'b1;
      end else begin
        hits_d = sum[COUNT_WIDTH-1:0];
      end
    end
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= CMP_GT;
      n_q     <= '0;
      beats_q <= '0;
      hits_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      n_q     <= n_d;
      beats_q <= beats_d;
      hits_q  <= hits_d;
      sat_q   <= sat_d;
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    in_ready = (state_q == RUN);
    busy     = (state_q == RUN) || (state_q == DRAIN);
    done     = (state_q == DONE);
    hits     = hits_q;
    beats    = beats_q;
    sat      = sat_q;
  end

endmodule

// File: tb/tb_mc_compare_accum.sv
// Scoreboard bench: a 32-bit-count DUT and a 3-bit-count DUT share one stimulus stream.
module tb_mc_compare_accum;

  localparam int IW  = 4;
  localparam int CH  = 2;
  localparam int CW  = 32;
  localparam int CWS = 3;
  localparam int SMAX = 7;
`ifdef MC_CMP_PIPE_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic              clk = 1'b0;
  logic              rst, start, cmp_mode, in_valid;
  logic [CW-1:0]     n_samples;
  logic [CH*IW-1:0]  a, b;

  logic              rdy, sat, busy, done;
  logic [CW-1:0]     hits, beats;
  logic              rdy_s, sat_s, busy_s, done_s;
  logic [CWS-1:0]    hits_s, beats_s;

  mc_compare_accum #(.INPUT_WIDTH(IW), .CHANNELS(CH), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .n_samples(n_samples), .cmp_mode(cmp_mode),
    .in_valid(in_valid), .a(a), .b(b), .in_ready(rdy), .hits(hits), .beats(beats),
    .sat(sat), .busy(busy), .done(done)
  );

  mc_compare_accum #(.INPUT_WIDTH(IW), .CHANNELS(CH), .COUNT_WIDTH(CWS)) dut_s (
    .clk(clk), .rst(rst), .start(start), .n_samples(n_samples[CWS-1:0]),
    .cmp_mode(cmp_mode), .in_valid(in_valid), .a(a), .b(b), .in_ready(rdy_s),
    .hits(hits_s), .beats(beats_s), .sat(sat_s), .busy(busy_s), .done(done_s)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     cyc;
    int     beats;
    longint h;
    int     hs;
    bit     ss;
  } exp_t;

  exp_t bq[$];
  exp_t hq[$];
  exp_t rq[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: results expected to be held by the DUTs.
  int     m_beats;
  longint m_h;
  int     m_hs;
  bit     m_ss;

  function automatic void chk(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int hit_count(logic [CH*IW-1:0] va, logic [CH*IW-1:0] vb, bit ge);
    int cnt = 0;
    for (int c = 0; c < CH; c++) begin
      int x = int'(va[c*IW +: IW]);
      int y = int'(vb[c*IW +: IW]);
      if (ge ? (x >= y) : (x > y)) cnt++;
    end
    return cnt;
  endfunction

  // Monitor: checks per-beat counts, delayed hits, and the final result at each done pulse.
  always @(negedge clk) begin
    exp_t e;
    while (bq.size() > 0 && bq[0].cyc <= cyc) begin
      e = bq.pop_front();
      chk("beats", beats, e.beats);
      chk("beats_small", beats_s, e.beats);
    end
    while (hq.size() > 0 && hq[0].cyc <= cyc) begin
      e = hq.pop_front();
      chk("hits", hits, e.h);
      chk("hits_small", hits_s, e.hs);
      chk("sat_small", sat_s, e.ss);
      chk("sat", sat, 0);
    end
    if (done || done_s) begin
      chk("done_pair", done_s, done);
      if (rq.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = rq.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("final_hits", hits, e.h);
        chk("final_beats", beats, e.beats);
        chk("final_sat", sat, 0);
        chk("final_hits_small", hits_s, e.hs);
        chk("final_beats_small", beats_s, e.beats);
        chk("final_sat_small", sat_s, e.ss);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_ready"}, rdy, 0);
    chk({tag, "_hits"}, hits, 0);
    chk({tag, "_beats"}, beats, 0);
    chk({tag, "_sat"}, sat, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_hits_small"}, hits_s, 0);
    chk({tag, "_beats_small"}, beats_s, 0);
    chk({tag, "_sat_small"}, sat_s, 0);
  endtask

  // Idle cycles with random junk on the beat inputs; results must hold and no beat may enter.
  task automatic idle(int k);
    for (int i = 0; i < k; i++) begin
      tick();
      start    = 1'b0;
      in_valid = 1'($urandom_range(0, 1));
      a        = (CH*IW)'($urandom);
      b        = (CH*IW)'($urandom);
      chk("ready_low", rdy, 0);
      chk("ready_low_small", rdy_s, 0);
      if (i >= 2) begin
        chk("hold_beats", beats, m_beats);
        chk("hold_hits", hits, m_h);
        chk("hold_hits_small", hits_s, m_hs);
        chk("hold_sat_small", sat_s, m_ss);
      end
    end
  endtask

  // opk: 0 random operands, 1 reference stream, 2 all hits.
  // vpat: 0 always valid, 1 toggling, 2 random. abort_after>0 resets after that many beats.
  task automatic run(int n, bit mode, int opk, int vpat, bit mid_start, int abort_after);
    logic [CH*IW-1:0] ta [3];
    logic [CH*IW-1:0] tb [3];
    int k = 0;
    int step = 0;
    int pc;
    ta[0] = 8'h51; ta[1] = 8'h99; ta[2] = 8'hF0;
    tb[0] = 8'h32; tb[1] = 8'h98; tb[2] = 8'h01;

    tick();
    start     = 1'b1;
    n_samples = CW'(n);
    cmp_mode  = mode;
    in_valid  = 1'b0;
    m_beats = 0; m_h = 0; m_hs = 0; m_ss = 1'b0;
    if (n == 0) begin
      rq.push_back('{cyc + 1, 0, 0, 0, 1'b0});
    end
    while (k < n) begin
      tick();
      start = mid_start && (step == 1);
      if (start) begin
        n_samples = CW'($urandom_range(1, 7));
        cmp_mode  = ~mode;
      end
      chk("ready_high", rdy, 1);
      chk("ready_high_small", rdy_s, 1);
      chk("busy_high", busy, 1);
      case (vpat)
        0:       in_valid = 1'b1;
        1:       in_valid = (step % 2) == 1;
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      case (opk)
        1: begin a = ta[k % 3]; b = tb[k % 3]; end
        2: begin a = '1; b = '0; end
        default: begin a = (CH*IW)'($urandom); b = (CH*IW)'($urandom); end
      endcase
      if (in_valid) begin
        pc = hit_count(a, b, mode);
        k++;
        m_beats = k;
        m_h     = m_h + pc;
        if (m_hs + pc > SMAX) begin
          m_hs = SMAX;
          m_ss = 1'b1;
        end else begin
          m_hs = m_hs + pc;
        end
        bq.push_back('{cyc + 1, m_beats, m_h, m_hs, m_ss});
        hq.push_back('{cyc + 1 + LAT, m_beats, m_h, m_hs, m_ss});
        if (k == n) rq.push_back('{cyc + 1 + LAT, m_beats, m_h, m_hs, m_ss});
      end
      step++;
      if (abort_after > 0 && k == abort_after) begin
        tick();
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        bq.delete();
        hq.delete();
        tick();
        chk_all_zero("abort");
        rst = 1'b0;
        m_beats = 0; m_h = 0; m_hs = 0; m_ss = 1'b0;
        break;
      end
    end
    idle(4);
    chk("done_seen", rq.size(), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cmp_mode = 1'b0; in_valid = 1'b0;
    n_samples = '0; a = '0; b = '0;
    m_beats = 0; m_h = 0; m_hs = 0; m_ss = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    idle(3);

    run(3, 1'b0, 1, 0, 1'b0, 0);   // expect hits 3
    run(3, 1'b1, 1, 0, 1'b0, 0);   // expect hits 4
    run(0, 1'b0, 0, 0, 1'b0, 0);   // immediate done
    run(4, 1'b0, 2, 1, 1'b1, 0);   // toggling valid, ignored mid-run start
    run(5, 1'b0, 2, 0, 1'b0, 0);   // small counter saturates
    run(6, 1'b0, 0, 0, 1'b0, 2);   // aborted by reset
    run(3, 1'b0, 1, 0, 1'b0, 0);   // normal run after abort
    for (int r = 0; r < 24; r++) begin
      run($urandom_range(0, 7), 1'($urandom_range(0, 1)), 0, 2,
          1'($urandom_range(0, 1)), 0);
    end

    chk("beat_queue_empty", bq.size(), 0);
    chk("hit_queue_empty", hq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
